// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants, crossbar index encoding and control-entry helpers.
// Index j order on both crossbars: 0=u0/x0, 1=v0/y0, ... 6=u3/x3, 7=v3/y3.
package ntt_pkg;
  localparam int NUM_BANKS = 8;
  localparam int SEL_W     = 3;
  localparam int BF_OUTS   = 8;

  typedef logic [BF_OUTS-1:0][SEL_W-1:0] dst_vec_t;

  // Control entry: destination bank codes plus per-result bank addresses.
  function automatic int ctrl_entry_w(input int addr_w);
    return BF_OUTS * (SEL_W + addr_w);
  endfunction
endpackage

// File: rtl/bf_ctrl_fifo.sv
// Generic synchronous FIFO, head visible combinationally; push lands next cycle.
// Backpressure: push when full is dropped unless a same-cycle pop frees a slot.
module bf_ctrl_fifo #(
  parameter int width = 8,
  parameter int depth = 8,
  localparam int idx_w = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [idx_w:0]   level
);
  logic [idx_w:0]   wr_ptr, rd_ptr;
  logic [width-1:0] mem [depth];
  logic             push_ok, pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == (idx_w+1)'(depth));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign rdata   = mem[rd_ptr[idx_w-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[idx_w-1:0]] <= wdata;
  end
endmodule

// File: rtl/control_bf_out_unit.sv
// Butterfly write-back router: pops a control entry per result group, drives bank writes 1 cycle later.
// Backpressure: none; overflow pushes are dropped and underflow pops ignored, both flagged sticky.
module control_bf_out_unit
  import ntt_pkg::*;
#(
  parameter int data_width = 256,
  parameter int addr_width = 10,
  parameter int fifo_depth = 8,
  localparam int lvl_w = $clog2(fifo_depth) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [SEL_W-1:0]      dst_0, dst_1, dst_2, dst_3, dst_4, dst_5, dst_6, dst_7,
  input  logic [addr_width-1:0] addr_0, addr_1, addr_2, addr_3, addr_4, addr_5, addr_6, addr_7,
  input  logic                  res_valid,
  input  logic [data_width-1:0] x0, y0, x1, y1, x2, y2, x3, y3,
  input  logic                  clr_err,
  output logic                  we0, we1, we2, we3, we4, we5, we6, we7,
  output logic [addr_width-1:0] waddr0, waddr1, waddr2, waddr3, waddr4, waddr5, waddr6, waddr7,
  output logic [data_width-1:0] d0, d1, d2, d3, d4, d5, d6, d7,
  output logic [lvl_w-1:0]      level,
  output logic                  err_ovf,
  output logic                  err_unf,
  output logic                  err_col
);
  typedef struct packed {
    dst_vec_t                               dst;
    logic [BF_OUTS-1:0][addr_width-1:0]     addr;
  } ctrl_entry_t;

  localparam int entry_w = ctrl_entry_w(addr_width);

  ctrl_entry_t           push_ent, head_ent;
  logic [entry_w-1:0]    head_raw;
  logic                  full, empty, pop_ok;
  logic [data_width-1:0] res [BF_OUTS];

  always_comb begin
    push_ent.dst  = {dst_7, dst_6, dst_5, dst_4, dst_3, dst_2, dst_1, dst_0};
    push_ent.addr = {addr_7, addr_6, addr_5, addr_4, addr_3, addr_2, addr_1, addr_0};
  end

  assign res = '{x0, y0, x1, y1, x2, y2, x3, y3};

  bf_ctrl_fifo #(.width(entry_w), .depth(fifo_depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue_valid),
    .pop   (res_valid),
    .wdata (push_ent),
    .rdata (head_raw),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign head_ent = ctrl_entry_t'(head_raw);
  assign pop_ok   = res_valid && !empty;

  // Later j overrides earlier j, so the highest-index result wins a shared bank.
  logic [NUM_BANKS-1:0] hit;
  logic [SEL_W-1:0]     sel [NUM_BANKS];
  logic                 col;

  always_comb begin
    col = 1'b0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      hit[k] = 1'b0;
      sel[k] = '0;
      for (int j = 0; j < BF_OUTS; j++) begin
        if (head_ent.dst[j] == SEL_W'(k)) begin
          hit[k] = 1'b1;
          sel[k] = SEL_W'(j);
        end
      end
    end
    for (int i = 1; i < BF_OUTS; i++)
      for (int j = 0; j < i; j++)
        if (head_ent.dst[i] == head_ent.dst[j]) col = 1'b1;
  end

  logic [NUM_BANKS-1:0]  we_r;
  logic [addr_width-1:0] waddr_r [NUM_BANKS];
  logic [data_width-1:0] d_r     [NUM_BANKS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_r    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_col <= 1'b0;
      for (int k = 0; k < NUM_BANKS; k++) begin
        waddr_r[k] <= '0;
        d_r[k]     <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_BANKS; k++) begin
        we_r[k] <= pop_ok && hit[k];
        if (pop_ok && hit[k]) begin
          waddr_r[k] <= head_ent.addr[sel[k]];
          d_r[k]     <= res[sel[k]];
        end
      end
      // A new error in the clearing cycle keeps its flag set.
      err_ovf <= (issue_valid && full && !pop_ok) || (err_ovf && !clr_err);
      err_unf <= (res_valid && empty) || (err_unf && !clr_err);
      err_col <= (pop_ok && col) || (err_col && !clr_err);
    end
  end

  assign {we7, we6, we5, we4, we3, we2, we1, we0} = we_r;
  assign waddr0 = waddr_r[0];
  assign waddr1 = waddr_r[1];
  assign waddr2 = waddr_r[2];
  assign waddr3 = waddr_r[3];
  assign waddr4 = waddr_r[4];
  assign waddr5 = waddr_r[5];
  assign waddr6 = waddr_r[6];
  assign waddr7 = waddr_r[7];
  assign d0 = d_r[0];
  assign d1 = d_r[1];
  assign d2 = d_r[2];
  assign d3 = d_r[3];
  assign d4 = d_r[4];
  assign d5 = d_r[5];
  assign d6 = d_r[6];
  assign d7 = d_r[7];
endmodule
